// File: rtl/fpu_share_arbiter.sv
// Time-shares one fpu_double between two requesters: grant, issue, wait for ready, capture, flush-reset.
// Optional WAIT watchdog enabled by defining FPU_ARB_TIMEOUT_EN (qNaN result plus err flag on expiry).
module fpu_share_arbiter #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [1:0]  rmode0,
  input  logic [1:0]  rmode1,
  input  logic [63:0] opa0,
  input  logic [63:0] opb0,
  input  logic [63:0] opa1,
  input  logic [63:0] opb1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] res0,
  output logic [63:0] res1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic        fpu_rst,
  output logic        fpu_enable,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  output logic [63:0] fpu_opa,
  output logic [63:0] fpu_opb,
  input  logic [63:0] fpu_out,
  input  logic        fpu_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

  localparam logic [3:0]  FLUSH_LAST = 4'(RST_CYCLES - 1);
  localparam logic [63:0] QNAN       = 64'h7FF8000000000000;

  state_t      state, state_d;
  logic        sel, sel_d, last, last_d, grant;
  logic [3:0]  flush_cnt, flush_cnt_d;
  logic        tmo_hit;
  logic        done0_d, done1_d, err0_d, err1_d;
  logic [63:0] res0_d, res1_d, fpu_opa_d, fpu_opb_d;
  logic [2:0]  fpu_op_d;
  logic [1:0]  fpu_rmode_d;
  logic        fpu_rst_d, fpu_enable_d, busy_d;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt, tmo_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt <= '0;
    else       tmo_cnt <= tmo_cnt_d;
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt;
    if (state == ISSUE)     tmo_cnt_d = '0;
    else if (state == WAIT) tmo_cnt_d = tmo_cnt + 8'd1;
  end

  assign tmo_hit = (state == WAIT) && !fpu_ready && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    sel_d       = sel;
    last_d      = last;
    flush_cnt_d = flush_cnt;
    grant       = 1'b0;
    fpu_op_d    = fpu_op;
    fpu_rmode_d = fpu_rmode;
    fpu_opa_d   = fpu_opa;
    fpu_opb_d   = fpu_opb;
    res0_d      = res0;
    res1_d      = res1;
    err0_d      = err0;
    err1_d      = err1;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins; a lone request always wins
          grant       = (req0 && req1) ? ~last : req1;
          sel_d       = grant;
          fpu_op_d    = grant ? op1    : op0;
          fpu_rmode_d = grant ? rmode1 : rmode0;
          fpu_opa_d   = grant ? opa1   : opa0;
          fpu_opb_d   = grant ? opb1   : opb0;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fpu_ready || tmo_hit) begin
          if (sel) begin
            res1_d  = fpu_ready ? fpu_out : QNAN;
            err1_d  = !fpu_ready;
            done1_d = 1'b1;
          end else begin
            res0_d  = fpu_ready ? fpu_out : QNAN;
            err0_d  = !fpu_ready;
            done0_d = 1'b1;
          end
          last_d      = sel;
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_d = IDLE;
        else                         flush_cnt_d = flush_cnt + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    fpu_rst_d    = (state_d == IDLE) || (state_d == FLUSH);
    fpu_enable_d = !fpu_rst_d;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last       <= 1'b1;
      flush_cnt  <= '0;
      fpu_rst    <= 1'b1;
      fpu_enable <= 1'b0;
      busy       <= 1'b0;
      fpu_op     <= '0;
      fpu_rmode  <= '0;
      fpu_opa    <= '0;
      fpu_opb    <= '0;
      res0       <= '0;
      res1       <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      state      <= state_d;
      sel        <= sel_d;
      last       <= last_d;
      flush_cnt  <= flush_cnt_d;
      fpu_rst    <= fpu_rst_d;
      fpu_enable <= fpu_enable_d;
      busy       <= busy_d;
      fpu_op     <= fpu_op_d;
      fpu_rmode  <= fpu_rmode_d;
      fpu_opa    <= fpu_opa_d;
      fpu_opb    <= fpu_opb_d;
      res0       <= res0_d;
      res1       <= res1_d;
      err0       <= err0_d;
      err1       <= err1_d;
      done0      <= done0_d;
      done1      <= done1_d;
    end
  end

endmodule
